aqalu_display_driver: RTL and testbench
=======================================

Name: aqalu_display_driver

Overview:
- Downstream consumer of the AQALU 8-bit Output bus. Runs in the same 10 MHz clock domain.
- Converts the unsigned result to three BCD digits (hundreds/tens/ones) with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a 3-digit common-anode seven-segment display for the board-level demo.

Parameters:
- REFRESH_DIV, 10000, clock cycles per digit slot (1 kHz digit rate at 10 MHz); legal range 2..2^20.

Ports:
- clock  in  1  system clock, 10 MHz nominal
- reset  in  1  synchronous, active-high reset
- Value  in  8  AQALU Output, unsigned 0..255
- BCD    out 12 {hundreds, tens, ones}, 4 bits each, last completed conversion
- Busy   out 1  high while a conversion is in progress
- Done   out 1  one-cycle pulse when BCD updates
- Seg    out 7  {g,f,e,d,c,b,a}, active-low segments for the selected digit
- Anode  out 3  active-low one-cold digit select; bit0 = ones, bit1 = tens, bit2 = hundreds

Behaviour:
- All state changes occur on posedge clock. reset is synchronous and active-high and has priority over all other logic.
- Reset values:
  - BCD = 12'h000; Busy = 0; Done = 0.
  - last_value = 8'h00; FSM in IDLE.
  - Refresh counter = 0; digit select = 0, so Anode = 3'b110 and Seg = 7'b1000000 (glyph "0").
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: at an edge where Value != last_value, capture Value into the shift register and into last_value. Clear the 12-bit BCD scratch and the iteration count. Go to SHIFT and set Busy = 1. If Value == last_value, stay in IDLE.
  - SHIFT: each edge, add 3 to every scratch nibble that is >= 5, then shift {scratch, shiftreg} left by 1. After the 8th iteration, go to DONE.
  - DONE: at the next edge, set BCD = scratch, pulse Done = 1 for one cycle, set Busy = 0, and return to IDLE.
- Latency: if the capture happens at edge k, BCD and Done are updated at edge k+9.
  - Busy is high for exactly 9 cycles.
  - The earliest next capture is at edge k+10.
- Value changes during SHIFT or DONE are ignored mid-flight. The compare in IDLE re-samples Value afterwards, so the final settled value is always converted.
- A Value of 0 right after reset starts no conversion, because BCD is already 000.
- Reset mid-conversion: the conversion is aborted, with no Done pulse, and all registers return to their reset values.
- Display refresh runs independently of the FSM.
  - The counter counts 0..REFRESH_DIV-1. At wrap, digit select advances 0 -> 1 -> 2 -> 0.
  - Anode follows the digit select: 110 -> 101 -> 011.
  - Seg is the registered decode of the selected BCD nibble, so it is aligned with Anode in the same cycle.
- Seg decode (active low, {g..a}):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Nibbles >= 10 are unreachable; the decoder outputs blank (1111111) for them.
- A BCD update while a digit is displayed shows the new digit from the next cycle.

Optional Feature:
- Macro: AQALU_LEADING_ZERO_BLANK_EN
- Defined:
  - The hundreds digit is blank (Seg = 1111111 while its anode is active) when hundreds == 0.
  - The tens digit is blank when hundreds == 0 and tens == 0.
  - The ones digit is never blanked.
  - The Anode sequence is unchanged.
- Undefined: all three digits are always shown, including leading zeros. The BCD port is identical in both builds.

Test Plan:
- Reset held 2 cycles, then released with Value = 0 -> BCD = 000, Busy = 0, Done never pulses, Anode = 110, Seg = 1000000.
- Value = 8'd255 at edge k -> Busy high for cycles k..k+8, BCD = 12'h255 and Done = 1 at edge k+9, Done = 0 at k+10.
- Value = 123, then changed to 45 at edge k+3 -> BCD = 12'h123 at k+9, new capture at k+10, BCD = 12'h045 at k+19; exactly two Done pulses.
- REFRESH_DIV = 4, BCD = 12'h207 -> Anode 110/101/011, each held 4 cycles, repeating; Seg 1111000 / 1000000 / 0100100 in step.
- Value = 200, reset asserted at k+4 -> Busy = 0 and BCD = 000 after reset; no Done; after release, BCD = 12'h200 at 10 cycles from the first IDLE edge.
- With AQALU_LEADING_ZERO_BLANK_EN, Value = 7 -> Seg = 1111111 in the hundreds and tens slots, 1111000 in the ones slot. Without the macro, the hundreds and tens slots show 1000000.

Source files
------------

// File: rtl/aqalu_display_driver.sv
// ---------------------------------------------------------------------------
// aqalu_display_driver
//
// Purpose: takes the unsigned 8-bit AQALU result, converts it to three BCD
// digits with a sequential shift-add-3 (double-dabble) engine, and
// time-multiplexes those digits onto a 3-digit common-anode 7-segment display.
//
// Ports:
//   clock  in   1  system clock (10 MHz nominal)
//   reset  in   1  synchronous, active-high reset
//   Value  in   8  AQALU output, unsigned 0..255
//   BCD    out 12  {hundreds, tens, ones} of the last completed conversion
//   Busy   out  1  high while a conversion is in progress
//   Done   out  1  one-cycle pulse when BCD updates
//   Seg    out  7  {g,f,e,d,c,b,a}, active-low segments of the selected digit
//   Anode  out  3  active-low one-cold digit select (bit0 ones .. bit2 hundreds)
//
// Build option: AQALU_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (hundreds when zero, tens when hundreds and tens are both zero).
// ---------------------------------------------------------------------------
module aqalu_display_driver #(
    parameter int unsigned REFRESH_DIV = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  Value,
    output logic [11:0] BCD,
    output logic        Busy,
    output logic        Done,
    output logic [6:0]  Seg,
    output logic [2:0]  Anode
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        last_q, last_d;
    logic [7:0]        shift_q, shift_d;
    logic [11:0]       scratch_q, scratch_d;
    logic [2:0]        iter_q, iter_d;
    logic [11:0]       bcd_q, bcd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic [2:0]        anode_q, anode_d;
    logic [6:0]        seg_q, seg_d;
    logic [19:0]       dabble_s;
    logic [3:0]        nibble_s;
    logic              blank_s;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = s[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Active-low {g..a} glyph for a BCD digit; out-of-range codes show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // One double-dabble step: adjust the scratch, then shift {scratch, shiftreg}.
    assign dabble_s = {dabble_adjust(scratch_q), shift_q} << 1;

    // Conversion FSM next-state and output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Value != last_q) begin
                    last_d    = Value;
                    shift_d   = Value;
                    scratch_d = 12'h000;
                    iter_d    = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SHIFT: begin
                scratch_d = dabble_s[19:8];
                shift_d   = dabble_s[7:0];
                iter_d    = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Display refresh: slot counter, digit select and the registered glyph.
    // Anode and Seg are both derived from the next digit select so they
    // change together on the same edge.
    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (digit_q == 2'd2) begin
                digit_d = 2'd0;
            end else begin
                digit_d = digit_q + 2'd1;
            end
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        case (digit_d)
            2'd0: begin
                anode_d  = 3'b110;
                nibble_s = bcd_q[3:0];
                blank_s  = 1'b0;
            end
            2'd1: begin
                anode_d  = 3'b101;
                nibble_s = bcd_q[7:4];
`ifdef AQALU_LEADING_ZERO_BLANK_EN
                blank_s  = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`else
                blank_s  = 1'b0;
`endif
            end
            2'd2: begin
                anode_d  = 3'b011;
                nibble_s = bcd_q[11:8];
`ifdef AQALU_LEADING_ZERO_BLANK_EN
                blank_s  = (bcd_q[11:8] == 4'd0);
`else
                blank_s  = 1'b0;
`endif
            end
            default: begin
                anode_d  = 3'b111;
                nibble_s = 4'hF;
                blank_s  = 1'b1;
            end
        endcase
        if (blank_s) begin
            seg_d = 7'b1111111;
        end else begin
            seg_d = seg_decode(nibble_s);
        end
    end

    // State registers; reset has priority and aborts any conversion in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= 8'h00;
            shift_q   <= 8'h00;
            scratch_q <= 12'h000;
            iter_q    <= 3'd0;
            bcd_q     <= 12'h000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            digit_q   <= 2'd0;
            anode_q   <= 3'b110;
            seg_q     <= 7'b1000000;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
        end
    end

    assign BCD   = bcd_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Seg   = seg_q;
    assign Anode = anode_q;

endmodule

// File: tb/tb_aqalu_display_driver.sv
// ---------------------------------------------------------------------------
// tb_aqalu_display_driver
//
// Bench for aqalu_display_driver with REFRESH_DIV = 4. A reference model
// (decimal arithmetic on the value, busy-window bookkeeping per edge) pushes
// the expected conversion results into a queue; a monitor on the falling
// edge pops them whenever Done is seen and also checks Busy, BCD, Anode and
// Seg every cycle. Honours AQALU_LEADING_ZERO_BLANK_EN like the design.
// ---------------------------------------------------------------------------
module tb_aqalu_display_driver;

    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  Value;
    logic [11:0] BCD;
    logic        Busy;
    logic        Done;
    logic [6:0]  Seg;
    logic [2:0]  Anode;

    aqalu_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clock (clock),
        .reset (reset),
        .Value (Value),
        .BCD   (BCD),
        .Busy  (Busy),
        .Done  (Done),
        .Seg   (Seg),
        .Anode (Anode)
    );

    always #50 clock = ~clock;

    typedef struct {
        logic [11:0] bcd;
        int          done_at;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // reference model state
    int          edge_n   = 0;
    bit          m_init   = 1'b0;
    bit          m_active = 1'b0;
    int          m_done_at;
    logic [7:0]  m_last   = 8'h00;
    logic [11:0] m_bcd    = 12'h000;
    logic [11:0] m_pend   = 12'h000;
    logic [11:0] m_seg_bcd = 12'h000;
    int          m_tick   = 0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int slot, input logic [11:0] b);
        int h, t, o;
        bit blank_en;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        o = int'(b[3:0]);
`ifdef AQALU_LEADING_ZERO_BLANK_EN
        blank_en = 1'b1;
`else
        blank_en = 1'b0;
`endif
        if (slot == 0) return glyph(o);
        if (slot == 1) return (blank_en && h == 0 && t == 0) ? 7'b1111111 : glyph(t);
        return (blank_en && h == 0) ? 7'b1111111 : glyph(h);
    endfunction

    function automatic logic [2:0] exp_anode(input int slot);
        if (slot == 0) return 3'b110;
        if (slot == 1) return 3'b101;
        return 3'b011;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, req);
        end
    endtask

    // Reference model, advanced once per rising edge.
    always @(posedge clock) begin
        logic [11:0] prev_bcd;
        edge_n++;
        prev_bcd = m_bcd;
        if (reset === 1'b1) begin
            m_init    = 1'b1;
            m_active  = 1'b0;
            m_last    = 8'h00;
            m_bcd     = 12'h000;
            m_seg_bcd = 12'h000;
            m_tick    = 0;
            exp_q.delete();
        end else begin
            m_tick++;
            m_seg_bcd = prev_bcd;
            if (m_active) begin
                if (edge_n == m_done_at) begin
                    m_active = 1'b0;
                    m_bcd    = m_pend;
                end
            end else if (Value != m_last) begin
                exp_t e;
                m_last    = Value;
                m_active  = 1'b1;
                m_done_at = edge_n + 9;
                m_pend    = to_bcd(int'(Value));
                e.bcd     = m_pend;
                e.done_at = m_done_at;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs against the model on the falling edge.
    always @(negedge clock) begin
        if (m_init) begin
            int slot;
            exp_t e;
            slot = (m_tick / DIV) % 3;
            check("busy", 32'(Busy), 32'(m_active));
            check("bcd", 32'(BCD), 32'(m_bcd));
            check("anode", 32'(Anode), 32'(exp_anode(slot)));
            check("seg", 32'(Seg), 32'(exp_seg(slot, m_seg_bcd)));
            if (Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_spurious at edge %0d: got Done=1, expected no pulse", edge_n);
                end else begin
                    e = exp_q.pop_front();
                    check("done_bcd", 32'(BCD), 32'(e.bcd));
                    check("done_edge", 32'(edge_n), 32'(e.done_at));
                end
            end else if (exp_q.size() > 0 && exp_q[0].done_at <= edge_n) begin
                e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL done_missing at edge %0d: got Done=%b, expected pulse with BCD %0h",
                         edge_n, Done, e.bcd);
            end else begin
                check("done_low", 32'(Done), 32'd0);
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Stimulus: directed scenarios first, then randomized values and resets.
    initial begin
        reset = 1'b1;
        Value = 8'd0;
        hold(2);
        reset = 1'b0;
        hold(14);                       // Value 0 after reset: no conversion
        Value = 8'd255;
        hold(14);
        Value = 8'd123;
        hold(3);
        Value = 8'd45;                  // changed mid-flight
        hold(24);
        Value = 8'd200;
        hold(4);
        reset = 1'b1;                   // abort conversion
        hold(1);
        reset = 1'b0;
        hold(16);
        Value = 8'd7;
        hold(20);
        Value = 8'd207;
        hold(20);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                Value = 8'($urandom_range(0, 12));
            end else begin
                Value = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                hold($urandom_range(1, 2));
                reset = 1'b0;
            end
            hold($urandom_range(1, 14));
        end
        hold(30);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
